pio_bus_master: RTL

//  Avalon-MM initiator for the 2-bit-address, fixed-latency PIO/GPIO slaves in this system (no waitrequest).

---
 rtl/pio_bus_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pio_bus_master.sv
// Avalon-MM initiator for fixed-latency PIO slaves: runs one write, read or
// poll-until-match command at a time and returns one response per command.
module pio_bus_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_POLLS    = 1000,
    parameter int POLL_GAP     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_GAP      = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;
    localparam logic [1:0] RSP_ILLEGAL = 2'b10;

    localparam logic [3:0]  LAT_LAST   = 4'(READ_LATENCY - 1);
    localparam logic [7:0]  GAP_LAST   = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
    localparam logic [15:0] POLL_LIMIT = 16'(MAX_POLLS);

    state_t             state;
    logic [1:0]         op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  mask_q;
    logic [3:0]         lat_cnt;
    logic [7:0]         gap_cnt;
    logic [15:0]        poll_cnt;
    logic [15:0]        poll_cnt_inc;
    logic               poll_match;

    assign poll_cnt_inc = poll_cnt + 16'd1;
    assign poll_match   = ((m_readdata & mask_q) == (data_q & mask_q));
    assign dbg_state    = state;

    // Handshakes: a command transfers on a cycle with cmd_valid && cmd_ready,
    // a response on a cycle with rsp_valid && rsp_ready; rsp_* hold until then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_status   <= RSP_OK;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= '0;
            m_writedata  <= '0;
            op_q         <= OP_WRITE;
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            lat_cnt      <= 4'd0;
            gap_cnt      <= 8'd0;
            poll_cnt     <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        addr_q    <= cmd_address;
                        data_q    <= cmd_data;
                        mask_q    <= cmd_mask;
                        poll_cnt  <= 16'd0;
                        case (cmd_op)
                            OP_WRITE: begin
                                state        <= ST_WR;
                                m_chipselect <= 1'b1;
                                m_write_n    <= 1'b0;
                                m_address    <= cmd_address;
                                m_writedata  <= cmd_data;
                            end
                            OP_READ, OP_POLL: begin
                                state        <= ST_RD_ISSUE;
                                m_chipselect <= 1'b1;
                                m_write_n    <= 1'b1;
                                m_address    <= cmd_address;
                            end
                            default: begin
                                state      <= ST_RESP;
                                rsp_valid  <= 1'b1;
                                rsp_data   <= '0;
                                rsp_status <= RSP_ILLEGAL;
                            end
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                ST_WR: begin
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                    state        <= ST_RESP;
                    rsp_valid    <= 1'b1;
                    rsp_data     <= '0;
                    rsp_status   <= RSP_OK;
                end

                ST_RD_ISSUE: begin
                    m_chipselect <= 1'b0;
                    lat_cnt      <= LAT_LAST;
                    state        <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else if (op_q != OP_POLL) begin
                        state      <= ST_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= m_readdata;
                        rsp_status <= RSP_OK;
                    end else begin
                        // Poll: count the attempt, then match, give up, or go round again.
                        poll_cnt <= poll_cnt_inc;
                        if (poll_match) begin
                            state      <= ST_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= m_readdata;
                            rsp_status <= RSP_OK;
                        end else if (poll_cnt_inc == POLL_LIMIT) begin
                            state      <= ST_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= m_readdata;
                            rsp_status <= RSP_TIMEOUT;
                        end else if (POLL_GAP == 0) begin
                            state        <= ST_RD_ISSUE;
                            m_chipselect <= 1'b1;
                            m_address    <= addr_q;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LAST;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt != 8'd0) begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end else begin
                        state        <= ST_RD_ISSUE;
                        m_chipselect <= 1'b1;
                        m_address    <= addr_q;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    cmd_ready    <= 1'b0;
                    rsp_valid    <= 1'b0;
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                end
            endcase
        end
    end

endmodule
